prio_enc_arb: RTL and testbench

- Parametrised, registered successor to the 8:3 combinational priority encoder.
- Encodes an N-bit request vector to a binary index plus one-hot grant.
- Modes: fixed priority (highest index wins) or round-robin rotating priority.
- Result presented on a valid/ready output; a grant is held stable until accepted, so the block can feed a downstream consumer or bus arbiter directly.

---
 rtl/prio_enc_arb.sv | 126 ++++++++++++
 tb/tb_prio_enc_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_enc_arb: registered N-input priority encoder / round-robin      |
// | arbiter with a held valid/ready grant output.                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prio_enc_arb #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic [N-1:0]  out_onehot,
    output logic [IW-1:0] last_idx
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_d;
    logic          r_valid;
    logic          w_valid_d;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_d;
    logic [N-1:0]  r_onehot;
    logic [N-1:0]  w_onehot_d;
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_last_d;

    logic [IW-1:0] w_ptr;
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_masked;
    logic [IW-1:0] w_win_idx;
    logic          w_any_req;

    function automatic logic [IW-1:0] f_highest(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    // On an accept the pointer is the grant being retired, not the stale last_idx.
    assign w_ptr     = (r_state == S_HOLD) ? r_idx : r_last;
    assign w_any_req = |req;

    // Indices below the pointer form the upper priority band; falling back to
    // the full vector gives the wrap N-1..p without any modulo arithmetic.
    for (genvar i = 0; i < N; i++) begin : g_mask
        assign w_mask[i] = (IW'(i) < w_ptr);
    end

    assign w_masked  = req & w_mask;
    assign w_win_idx = (mode && (|w_masked)) ? f_highest(w_masked) : f_highest(req);

    always_comb begin
        w_state_d  = r_state;
        w_valid_d  = r_valid;
        w_idx_d    = r_idx;
        w_onehot_d = r_onehot;
        w_last_d   = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_valid_d  = 1'b1;
                    w_idx_d    = w_win_idx;
                    w_onehot_d = C_ONE << w_win_idx;
                    w_state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_last_d = r_idx;
                    if (w_any_req) begin
                        w_idx_d    = w_win_idx;
                        w_onehot_d = C_ONE << w_win_idx;
                    end else begin
                        w_valid_d  = 1'b0;
                        w_onehot_d = '0;
                        w_state_d  = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_last   <= '0;
        end else begin
            r_state  <= w_state_d;
            r_valid  <= w_valid_d;
            r_idx    <= w_idx_d;
            r_onehot <= w_onehot_d;
            r_last   <= w_last_d;
        end
    end

    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign last_idx   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prio_enc_arb: directed scoreboard bench for prio_enc_arb (N=8, 6). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_prio_enc_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req8;
    logic       mode8;
    logic       rdy8;
    logic       v8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic [2:0] last8;
    logic [5:0] req6;
    logic       mode6;
    logic       rdy6;
    logic       v6;
    logic [2:0] idx6;
    logic [5:0] oh6;
    logic [2:0] last6;

    always #5 clk = ~clk;

    prio_enc_arb #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .out_ready(rdy8),
        .out_valid(v8), .out_idx(idx8), .out_onehot(oh8), .last_idx(last8)
    );

    prio_enc_arb #(.N(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req6), .mode(mode6), .out_ready(rdy6),
        .out_valid(v6), .out_idx(idx6), .out_onehot(oh6), .last_idx(last6)
    );

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
        logic [2:0] last;
    } exp_t;

    exp_t q8[$];
    int   q6[$];
    int   total = 0;
    int   bad   = 0;

    logic       m_v;
    logic [2:0] m_idx;
    logic [7:0] m_oh;
    logic [2:0] m_last;

    // Reference search walks p-1, p-2, ... with explicit modulo wrap.
    function automatic logic [2:0] ref_win(input logic [7:0] r, input logic md,
                                           input logic [2:0] p, input int n);
        int pe;
        int c;
        pe = md ? int'(p) : 0;
        for (int k = 1; k <= n; k++) begin
            c = (pe - k + n) % n;
            if (r[c]) return 3'(c);
        end
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 1'b0; m_idx = 3'd0; m_oh = 8'd0; m_last = 3'd0;
        q8.delete();
        q6.delete();
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
    task automatic step8(input logic [7:0] r, input logic rdy);
        logic [2:0] w;
        exp_t       e;
        exp_t       got;
        req8 = r;
        rdy8 = rdy;
        if (!m_v) begin
            if (|r) begin
                w = ref_win(r, mode8, m_last, 8);
                m_v = 1'b1; m_idx = w; m_oh = 8'd1 << w;
            end
        end else if (rdy) begin
            w = ref_win(r, mode8, m_idx, 8);
            m_last = m_idx;
            if (|r) begin
                m_idx = w; m_oh = 8'd1 << w;
            end else begin
                m_v = 1'b0; m_oh = 8'd0;
            end
        end
        q8.push_back('{v: m_v, idx: m_idx, oh: m_oh, last: m_last});
        @(posedge clk);
        #1;
        e = q8.pop_front();
        got = '{v: v8, idx: idx8, oh: oh8, last: last8};
        chk("n8_valid",  32'(got.v),    32'(e.v));
        chk("n8_idx",    32'(got.idx),  32'(e.idx));
        chk("n8_onehot", 32'(got.oh),   32'(e.oh));
        chk("n8_last",   32'(got.last), 32'(e.last));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid",  32'(v8),    32'd0);
        chk("rst_onehot", 32'(oh8),   32'd0);
        chk("rst_last",   32'(last8), 32'd0);
        chk("rst_idx",    32'(idx8),  32'd0);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[9];
        int exp_alt[4];
        int got6;
        rst_n = 1'b0;
        req8 = 8'd0; mode8 = 1'b0; rdy8 = 1'b0;
        req6 = 6'd0; mode6 = 1'b0; rdy6 = 1'b0;
        model_reset();
        #1;
        chk("reset_valid",  32'(v8),    32'd0);
        chk("reset_idx",    32'(idx8),  32'd0);
        chk("reset_onehot", 32'(oh8),   32'd0);
        chk("reset_last",   32'(last8), 32'd0);
        #3 rst_n = 1'b1;

        // Fixed priority, one-cycle latency.
        mode8 = 1'b0;
        step8(8'h01, 1'b1);
        chk("fix_first_idx", 32'(idx8), 32'd0);
        step8(8'hA6, 1'b1);
        chk("fix_second_idx", 32'(idx8), 32'd7);
        chk("fix_second_oh",  32'(oh8),  32'h80);
        step8(8'h00, 1'b1);

        // Held grant ignores request changes while not ready.
        step8(8'h30, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step8(8'h81, 1'b0);
            chk("hold_idx", 32'(idx8), 32'd5);
        end
        step8(8'h81, 1'b1);
        chk("accept_new_idx", 32'(idx8), 32'd7);
        chk("accept_last",    32'(last8), 32'd5);
        step8(8'h00, 1'b1);

        // Round-robin full rotation from a fresh pointer.
        pulse_reset();
        mode8 = 1'b1;
        exp_rr = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        for (int i = 0; i < 9; i++) begin
            step8(8'hFF, 1'b1);
            chk("rr_idx", 32'(idx8), 32'(exp_rr[i]));
        end
        step8(8'h00, 1'b1);

        // Two requesters alternate; empty request drops valid.
        pulse_reset();
        mode8 = 1'b1;
        exp_alt = '{7, 2, 7, 2};
        for (int i = 0; i < 4; i++) begin
            step8(8'h84, 1'b1);
            chk("alt_idx", 32'(idx8), 32'(exp_alt[i]));
        end
        step8(8'h00, 1'b1);
        chk("drop_valid",  32'(v8),  32'd0);
        chk("drop_onehot", 32'(oh8), 32'd0);
        chk("drop_keep_idx", 32'(idx8), 32'd2);

        // Reset in the middle of a held grant.
        mode8 = 1'b0;
        step8(8'h08, 1'b0);
        step8(8'h08, 1'b0);
        chk("pre_rst_idx", 32'(idx8), 32'd3);
        pulse_reset();
        mode8 = 1'b1;
        step8(8'hFF, 1'b1);
        chk("post_rst_idx", 32'(idx8), 32'd7);
        step8(8'h00, 1'b1);

        // Non-power-of-two width: pointer wrap 0 -> 5.
        mode6 = 1'b1;
        rdy6  = 1'b1;
        q6.push_back(5);
        q6.push_back(0);
        q6.push_back(5);
        for (int i = 0; i < 3; i++) begin
            req6 = 6'b10_0001;
            @(posedge clk);
            #1;
            got6 = q6.pop_front();
            chk("n6_valid",  32'(v6),   32'd1);
            chk("n6_idx",    32'(idx6), 32'(got6));
            chk("n6_onehot", 32'(oh6),  32'(6'd1 << got6));
            chk("n6_range",  32'(idx6 < 3'd6), 32'd1);
        end
        req6 = 6'd0;
        @(posedge clk);
        #1;
        chk("n6_drop_valid", 32'(v6),    32'd0);
        chk("n6_last",       32'(last6), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
